// File: rtl/md_scheduler.sv
// Multiply/divide issue scheduler: launches HI/LO ops, tracks latency, stalls D.
// Optional stall counter enabled by MD_SCHED_STALL_COUNT_EN.
module md_scheduler #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_kind,
  input  logic        flush,
  output logic        stall,
  output logic [4:0]  unit_ctrl,
  output logic        calculate,
  output logic        load_hi,
  output logic        load_lo,
  output logic        busy,
  output logic [3:0]  count,
  output logic [15:0] stall_cycles
);

  localparam logic [3:0] MULT_L = 4'(MULT_LAT);
  localparam logic [3:0] DIV_L  = 4'(DIV_LAT);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] count_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  assign busy = (state == RUN);

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    stall     = 1'b0;
    calculate = 1'b0;
    unit_ctrl = '0;
    load_hi   = 1'b0;
    load_lo   = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_valid && !flush && !reset) begin
          if (!op_kind[2]) begin
            unit_ctrl = {1'b1, op_kind[1], op_kind[0], 2'b00};
            state_nx  = RUN;
            count_nx  = op_kind[1] ? DIV_L : MULT_L;
          end else begin
            unit_ctrl = {3'b000, 1'b1, op_kind[0]};
            load_hi   = op_kind[1] & ~op_kind[0];
            load_lo   = op_kind[1] & op_kind[0];
          end
        end
      end
      RUN: begin
        stall = op_valid & ~flush;
        // flush takes priority over the commit pulse
        if (flush) begin
          state_nx = IDLE;
          count_nx = '0;
        end else if (count == 4'd1) begin
          calculate = 1'b1;
          state_nx  = IDLE;
          count_nx  = '0;
        end else begin
          count_nx = count - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

`ifdef MD_SCHED_STALL_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed sequences plus random traffic
// compared every cycle against an absolute-cycle behavioural model.
module tb_md_scheduler;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_kind = 3'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic [4:0]  unit_ctrl;
  logic        calculate;
  logic        load_hi;
  logic        load_lo;
  logic        busy;
  logic [3:0]  count;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  md_scheduler #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid),
    .op_kind(op_kind), .flush(flush), .stall(stall),
    .unit_ctrl(unit_ctrl), .calculate(calculate),
    .load_hi(load_hi), .load_lo(load_lo), .busy(busy),
    .count(count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: an in-flight op is remembered by the absolute cycle of its commit.
  int cyc = 0;
  bit inflight = 0;
  int commit_at = 0;
  int scnt = 0;

  always @(negedge clk) begin
    logic       e_stall, e_calc, acc, e_lh, e_ll;
    logic [4:0] e_uc;
    int         e_cnt;
    cyc++;
    if (reset) begin
      inflight = 0;
      scnt = 0;
      chk("rst_stall", {15'd0, stall}, 16'd0);
      chk("rst_uc", {11'd0, unit_ctrl}, 16'd0);
      chk("rst_calc", {15'd0, calculate}, 16'd0);
      chk("rst_lh", {15'd0, load_hi}, 16'd0);
      chk("rst_ll", {15'd0, load_lo}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_count", {12'd0, count}, 16'd0);
      chk("rst_scnt", stall_cycles, 16'd0);
    end else begin
      e_stall = op_valid && !flush && inflight;
      e_calc  = inflight && (cyc == commit_at) && !flush;
      acc     = op_valid && !flush && !inflight;
      e_cnt   = inflight ? (commit_at - cyc + 1) : 0;
      e_uc = 5'd0;
      e_lh = 1'b0;
      e_ll = 1'b0;
      if (acc) begin
        case (op_kind)
          3'd0: e_uc = 5'b10000;
          3'd1: e_uc = 5'b10100;
          3'd2: e_uc = 5'b11000;
          3'd3: e_uc = 5'b11100;
          3'd4: e_uc = 5'b00010;
          3'd5: e_uc = 5'b00011;
          3'd6: begin e_uc = 5'b00010; e_lh = 1'b1; end
          default: begin e_uc = 5'b00011; e_ll = 1'b1; end
        endcase
      end
      chk("stall", {15'd0, stall}, {15'd0, e_stall});
      chk("unit_ctrl", {11'd0, unit_ctrl}, {11'd0, e_uc});
      chk("calculate", {15'd0, calculate}, {15'd0, e_calc});
      chk("load_hi", {15'd0, load_hi}, {15'd0, e_lh});
      chk("load_lo", {15'd0, load_lo}, {15'd0, e_ll});
      chk("busy", {15'd0, busy}, {15'd0, inflight});
      chk("count", {12'd0, count}, 16'(e_cnt));
`ifdef MD_SCHED_STALL_COUNT_EN
      chk("stall_cycles", stall_cycles, 16'(scnt));
`else
      chk("stall_cycles", stall_cycles, 16'd0);
`endif
      if (e_stall && scnt < 65535) scnt++;
      if (flush || e_calc) inflight = 0;
      if (acc && !op_kind[2]) begin
        inflight = 1;
        commit_at = cyc + (op_kind[1] ? DL : ML);
      end
    end
  end

  // One cycle of stimulus; returns mid-cycle for literal checks.
  task automatic drive(input logic v, input logic [2:0] k,
                       input logic f, input logic r = 1'b0);
    @(posedge clk);
    #1;
    op_valid = v;
    op_kind  = k;
    flush    = f;
    reset    = r;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    op_valid = 1'b1;
    op_kind  = 3'b110;
    flush    = 1'b0;
    @(negedge clk);
    #1;
    reset    = 1'b0;
    op_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    drive(1, 3'b000, 0);
    chk("lit_mult_uc", {11'd0, unit_ctrl}, 16'b10000);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 3'b000, 0);
      chk("lit_mult_cnt", {12'd0, count}, 16'(6 - i));
      chk("lit_mult_calc", {15'd0, calculate}, {15'd0, i == 5});
    end
    drive(0, 3'b000, 0);
    chk("lit_mult_busy", {15'd0, busy}, 16'd0);

    do_reset();
    drive(1, 3'b011, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 3'b101, 0);
      chk("lit_divu_stall", {15'd0, stall}, 16'd1);
      chk("lit_divu_calc", {15'd0, calculate}, {15'd0, i == 10});
    end
    drive(1, 3'b101, 0);
    chk("lit_mflo_stall", {15'd0, stall}, 16'd0);
    chk("lit_mflo_uc", {11'd0, unit_ctrl}, 16'b00011);
`ifdef MD_SCHED_STALL_COUNT_EN
    chk("lit_scnt", stall_cycles, 16'd10);
`else
    chk("lit_scnt", stall_cycles, 16'd0);
`endif

    drive(1, 3'b010, 0);
    for (int i = 1; i <= 9; i++) drive(0, 3'b000, 0);
    drive(0, 3'b000, 1);
    chk("lit_flush_cnt1", {12'd0, count}, 16'd1);
    chk("lit_flush_calc", {15'd0, calculate}, 16'd0);
    drive(0, 3'b000, 0);
    chk("lit_flush_count", {12'd0, count}, 16'd0);
    chk("lit_flush_busy", {15'd0, busy}, 16'd0);

    drive(1, 3'b110, 0);
    chk("lit_mthi_lh", {15'd0, load_hi}, 16'd1);
    chk("lit_mthi_busy", {15'd0, busy}, 16'd0);
    drive(1, 3'b111, 0);
    chk("lit_mtlo_ll", {15'd0, load_lo}, 16'd1);
    chk("lit_mtlo_lh", {15'd0, load_hi}, 16'd0);
    chk("lit_mtlo_stall", {15'd0, stall}, 16'd0);
    chk("lit_mtlo_busy", {15'd0, busy}, 16'd0);

    drive(1, 3'b001, 0);
    drive(0, 3'b000, 0);
    drive(0, 3'b000, 0);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk("lit_pre_rst_cnt", {12'd0, count}, 16'd3);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("lit_async_cnt", {12'd0, count}, 16'd0);
    chk("lit_async_busy", {15'd0, busy}, 16'd0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 3'b000, 0);
      chk("lit_no_calc", {15'd0, calculate}, 16'd0);
    end

    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end
    drive(0, 3'b000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
